// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the fetch/data SRAM arbiter: FSM states,
// port identifiers and bus widths.
package mips_mem_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

endpackage

// File: rtl/mem_arbiter_sram_if.sv
// SRAM pin driver: registered strobes/address from the FSM's next state,
// tri-state write data, and two-phase read capture into per-port words.
module mem_arbiter_sram_if
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic                        clock,
    input  logic                        reset,
    input  arb_state_t                  state_reg,
    input  arb_state_t                  state_next,
    input  logic [((WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1)-1:0] cnt_reg,
    input  logic [((WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1)-1:0] cnt_next,
    input  logic                        acc_port,
    input  logic                        acc_we,
    input  logic [SRAM_AW-1:0]          acc_addr,
    input  logic [WORD_W-1:0]           acc_wdata,
    input  logic [3:0]                  acc_be,
    output logic [WORD_W-1:0]           if_rdata,
    output logic [WORD_W-1:0]           mem_rdata,
    output logic [SRAM_AW-1:0]          sram_addr,
    inout  wire  [SRAM_DW-1:0]          sram_data,
    output logic                        sram_ce_n,
    output logic                        sram_oe_n,
    output logic                        sram_we_n,
    output logic                        sram_ub_n,
    output logic                        sram_lb_n
);

    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    logic               in_phase_next;
    logic               hi_next;
    logic               last_now;
    logic [1:0]         lanes_next;
    logic               drive_reg;
    logic [SRAM_DW-1:0] dout_reg;
    logic [SRAM_DW-1:0] lo_reg;

    assign in_phase_next = (state_next == ST_LO) || (state_next == ST_HI);
    assign hi_next       = (state_next == ST_HI);
    assign last_now      = ((state_reg == ST_LO) || (state_reg == ST_HI)) && (cnt_reg == LAST_CNT);

    // Byte-lane enables of the upcoming phase: be[1:0] for LO, be[3:2] for HI
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lanes_next[gi] = hi_next ? acc_be[2 + gi] : acc_be[gi];
        end
    endgenerate

    assign sram_data = drive_reg ? dout_reg : {SRAM_DW{1'bz}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            drive_reg <= 1'b0;
            dout_reg  <= '0;
            lo_reg    <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            sram_ce_n <= ~in_phase_next;
            sram_oe_n <= ~(in_phase_next & ~acc_we);
            // First cycle of each phase is address setup; a phase with no lanes never strobes
            sram_we_n <= ~(in_phase_next & acc_we & (cnt_next != '0) & (|lanes_next));
            drive_reg <= in_phase_next & acc_we;
            dout_reg  <= hi_next ? acc_wdata[31:16] : acc_wdata[15:0];
            if (in_phase_next) begin
                sram_addr <= acc_addr | SRAM_AW'(hi_next);
                sram_lb_n <= acc_we ? ~lanes_next[0] : 1'b0;
                sram_ub_n <= acc_we ? ~lanes_next[1] : 1'b0;
            end else begin
                sram_lb_n <= 1'b1;
                sram_ub_n <= 1'b1;
            end
            // The port word is only replaced once both halves are in hand
            if (last_now && !acc_we) begin
                if (state_reg == ST_LO) begin
                    lo_reg <= sram_data;
                end else if (acc_port == PORT_IF) begin
                    if_rdata <= {sram_data, lo_reg};
                end else begin
                    mem_rdata <= {sram_data, lo_reg};
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one 16-bit async SRAM; each 32-bit access is a LO then HI phase.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests (default: mem over if).
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [SRAM_AW-1:0]  if_addr,
    output logic [WORD_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_stall,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [SRAM_AW-1:0]  mem_addr,
    input  logic [WORD_W-1:0]   mem_wdata,
    input  logic [3:0]          mem_be,
    output logic [WORD_W-1:0]   mem_rdata,
    output logic                mem_ack,
    output logic                mem_stall,
    output logic [SRAM_AW-1:0]  sram_addr,
    inout  wire  [SRAM_DW-1:0]  sram_data,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    arb_state_t         state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               port_reg;
    logic               we_reg;
    logic [SRAM_AW-1:0] addr_reg;
    logic [WORD_W-1:0]  wdata_reg;
    logic [3:0]         be_reg;

    logic               grant;
    logic               grant_port;
    logic               acc_port;
    logic               acc_we;
    logic [SRAM_AW-1:0] acc_addr;
    logic [WORD_W-1:0]  acc_wdata;
    logic [3:0]         acc_be;

`ifdef MEM_ARB_RR_EN
    logic last_grant_reg;

    always_comb begin
        if (if_req && mem_req) begin
            grant_port = (last_grant_reg == PORT_IF) ? PORT_MEM : PORT_IF;
        end else begin
            grant_port = mem_req ? PORT_MEM : PORT_IF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_reg <= PORT_IF;
        end else if (grant) begin
            last_grant_reg <= grant_port;
        end
    end
`else
    assign grant_port = mem_req ? PORT_MEM : PORT_IF;
`endif

    assign grant = (state_reg == ST_IDLE) && (if_req || mem_req);

    // Access fields as seen by the pin driver: the winner at the grant edge, the latch afterwards
    always_comb begin
        acc_port  = port_reg;
        acc_we    = we_reg;
        acc_addr  = addr_reg;
        acc_wdata = wdata_reg;
        acc_be    = be_reg;
        if (grant) begin
            acc_port  = grant_port;
            acc_we    = (grant_port == PORT_MEM) ? mem_we : 1'b0;
            acc_addr  = ((grant_port == PORT_MEM) ? mem_addr : if_addr) & ~SRAM_AW'(1);
            acc_wdata = mem_wdata;
            acc_be    = mem_be;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next = ST_LO;
                    cnt_next   = '0;
                end
            end
            ST_LO: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HI: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            port_reg  <= PORT_IF;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (grant) begin
                port_reg  <= acc_port;
                we_reg    <= acc_we;
                addr_reg  <= acc_addr;
                wdata_reg <= acc_wdata;
                be_reg    <= acc_be;
            end
        end
    end

    assign if_ack    = (state_reg == ST_DONE) && (port_reg == PORT_IF);
    assign mem_ack   = (state_reg == ST_DONE) && (port_reg == PORT_MEM);
    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    mem_arbiter_sram_if #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_sram_if (
        .clock      (clock),
        .reset      (reset),
        .state_reg  (state_reg),
        .state_next (state_next),
        .cnt_reg    (cnt_reg),
        .cnt_next   (cnt_next),
        .acc_port   (acc_port),
        .acc_we     (acc_we),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .acc_be     (acc_be),
        .if_rdata   (if_rdata),
        .mem_rdata  (mem_rdata),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

endmodule
